// File: rtl/alu_mul_seq_if.sv
// Handshake and result bundle between the front end and the alu_mul_seq controller.
// The front end uses the master modport and the multiplier uses the slave modport.
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             zr;
  logic             ng;
  logic [5:0]       alu_ctrl;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, zr, ng, alu_ctrl
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, zr, ng, alu_ctrl
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential 16-bit shift-and-add multiplier that drives a Hack-style ALU as its only adder.
// Each operation runs 16 fixed ADD/DBL iterations, then one FLAGS pass, so latency is 33 cycles.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] o,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  assign x_z   = zx ? 16'h0000 : x;
  assign x_n   = nx ? ~x_z : x_z;
  assign y_z   = zy ? 16'h0000 : y;
  assign y_n   = ny ? ~y_z : y_z;
  assign f_out = f ? (x_n + y_n) : (x_n & y_n);
  assign o     = no ? ~f_out : f_out;
  assign zr    = (o == 16'h0000);
  assign ng    = o[15];
endmodule

module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mul_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_DBL,
    S_FLAGS,
    S_DONE
  } state_t;

  localparam logic [5:0] CTRL_ZERO = 6'b101010;
  localparam logic [5:0] CTRL_ADD  = 6'b000010;
  localparam logic [5:0] CTRL_PASS = 6'b001100;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] product_q;
  logic             zr_q, ng_q;
  logic [3:0]       cnt;

  logic [WIDTH-1:0] alu_x, alu_y, alu_o;
  logic [5:0]       ctrl;
  logic             alu_zr, alu_ng;

  alu u_alu (
    .x  (alu_x),
    .y  (alu_y),
    .zx (ctrl[5]),
    .nx (ctrl[4]),
    .zy (ctrl[3]),
    .ny (ctrl[2]),
    .f  (ctrl[1]),
    .no (ctrl[0]),
    .o  (alu_o),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_ADD;
      S_ADD:   state_nxt = S_DBL;
      S_DBL:   state_nxt = (cnt == 4'd15) ? S_FLAGS : S_ADD;
      S_FLAGS: state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl  = CTRL_ZERO;
    alu_x = '0;
    alu_y = '0;
    case (state)
      S_ADD: begin
        ctrl  = CTRL_ADD;
        alu_x = acc;
        alu_y = mcand;
      end
      S_DBL: begin
        ctrl  = CTRL_ADD;
        alu_x = mcand;
        alu_y = mcand;
      end
      S_FLAGS: begin
        ctrl  = CTRL_PASS;
        alu_x = acc;
      end
      default: ;
    endcase
  end

  // Datapath registers; the ALU output is the only source of arithmetic results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
      zr_q      <= 1'b0;
      ng_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            acc    <= '0;
            mcand  <= bus.b;
            mplier <= bus.a;
            cnt    <= '0;
          end
        end
        S_ADD: begin
          if (mplier[0]) acc <= alu_o;
        end
        S_DBL: begin
          mcand  <= alu_o;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        S_FLAGS: begin
          product_q <= alu_o;
          zr_q      <= alu_zr;
          ng_q      <= alu_ng;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.product   = product_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.alu_ctrl  = ctrl;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: latency, control-word schedule, wrap/sign cases,
// backpressure, busy-time input rejection, mid-operation reset and random pairs.
module tb_alu_mul_seq;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_mul_seq_if #(.WIDTH(16)) bus ();

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] ctrl_log [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents the pair and releases in_valid after the accept edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_timeout", {31'd0, n < 100}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; optionally pulses in_valid mid-run.
  task automatic wait_done(input bit pulse, output int lat);
    int k;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 60) begin
      ctrl_log[k] = bus.alu_ctrl;
      if (pulse && k == 4) begin
        bus.in_valid = 1'b1;
        bus.a        = 16'd5;
        bus.b        = 16'd5;
      end
      if (pulse && k == 7) bus.in_valid = 1'b0;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    lat = k;
  endtask

  task automatic finish_op;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_p);
    int lat;
    start_op(av, bv);
    wait_done(1'b0, lat);
    check({tag, "_latency"}, lat, 33);
    check({tag, "_product"}, {16'd0, bus.product}, {16'd0, exp_p});
    check({tag, "_zr"}, {31'd0, bus.zr}, {31'd0, exp_p == 16'd0});
    check({tag, "_ng"}, {31'd0, bus.ng}, {31'd0, exp_p[15]});
    finish_op();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_product"}, {16'd0, bus.product}, 32'd0);
    check({tag, "_zr"}, {31'd0, bus.zr}, 32'd0);
    check({tag, "_ng"}, {31'd0, bus.ng}, 32'd0);
    check({tag, "_alu_ctrl"}, {26'd0, bus.alu_ctrl}, 32'b101010);
    check({tag, "_acc"}, {16'd0, dut.acc}, 32'd0);
    check({tag, "_mcand"}, {16'd0, dut.mcand}, 32'd0);
    check({tag, "_mplier"}, {16'd0, dut.mplier}, 32'd0);
    check({tag, "_cnt"}, {28'd0, dut.cnt}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          bad;
    logic [15:0] ra, rb, rp, held;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset");

    // 3*5 with out_ready already high: latency and control-word schedule.
    bus.out_ready = 1'b1;
    start_op(16'd3, 16'd5);
    wait_done(1'b0, lat);
    check("mul3x5_latency", lat, 33);
    check("mul3x5_product", {16'd0, bus.product}, 32'd15);
    check("mul3x5_zr", {31'd0, bus.zr}, 32'd0);
    check("mul3x5_ng", {31'd0, bus.ng}, 32'd0);
    bad = 0;
    for (int i = 0; i < 32; i++) if (ctrl_log[i] !== 6'b000010) bad++;
    check("mul3x5_ctrl_add_words", bad, 0);
    check("mul3x5_ctrl_flags_word", {26'd0, ctrl_log[32]}, 32'b001100);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("mul3x5_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("mul3x5_out_valid_after", {31'd0, bus.out_valid}, 32'd0);
    check("mul3x5_product_held", {16'd0, bus.product}, 32'd15);

    run_op("zero_a", 16'h0000, 16'(($urandom)), 16'h0000);
    run_op("neg_one", 16'hFFFF, 16'h0001, 16'hFFFF);
    run_op("wrap_256sq", 16'h0100, 16'h0100, 16'h0000);
    run_op("neg3x7", 16'hFFFD, 16'h0007, 16'hFFEB);

    // Backpressure: result and flags hold while out_ready stays low.
    start_op(16'd12, 16'd11);
    wait_done(1'b0, lat);
    check("bp_latency", lat, 33);
    held = bus.product;
    check("bp_product", {16'd0, held}, 32'd132);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.product !== 16'd132 || bus.in_ready !== 1'b0) bad++;
    end
    check("bp_stable_cycles", bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_in_ready_after_release", {31'd0, bus.in_ready}, 32'd1);

    // in_valid pulsed with other operands while busy must be ignored.
    start_op(16'd100, 16'd7);
    wait_done(1'b1, lat);
    check("busy_latency", lat, 33);
    check("busy_product", {16'd0, bus.product}, 32'h02BC);
    finish_op();
    check("busy_idle_after", {31'd0, bus.in_ready}, 32'd1);

    // Reset around iteration 8 aborts the operation.
    start_op(16'd1234, 16'd77);
    repeat (16) @(negedge clk);
    check("abort_busy_before_reset", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("abort");
    run_op("after_abort", 16'd2, 16'd9, 16'd18);

    // Random pairs against a bench-side product.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rp = 16'(ra * rb);
      run_op($sformatf("rand%0d", i), ra, rb, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiplier controller that sequences the existing Hack-style `alu` (ports `x, y, zx, nx, zy, ny, f, no, o, zr, ng`) as its only adder. It accepts an operand pair over a valid/ready handshake and runs a fixed shift-and-add schedule, issuing one ALU control word per cycle. It returns the low 16 bits of the product with the ALU's zero and negative flags. It sits between the instruction/test front end and the ALU and owns the ALU exclusively while busy.

## Interface
- `WIDTH`, 16, datapath width; fixed by `alu`, no other value is supported.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block idle and able to accept.
- `a`  in  16  multiplier, two's complement or unsigned; the result is the same mod 2^16.
- `b`  in  16  multiplicand.
- `out_valid`  out  1  result registered and held.
- `out_ready`  in  1  consumer accepts the result.
- `product`  out  16  (a*b) mod 2^16.
- `zr`  out  1  product == 0, taken from the ALU.
- `ng`  out  1  product[15], taken from the ALU.
- `alu_ctrl`  out  6  ALU control word `{zx,nx,zy,ny,f,no}` issued this cycle, for debug and coverage.

## Operation
- The block instantiates one `alu`. Internal registers are `acc`, `mcand`, `mplier`, and a 4-bit `cnt`.
- **IDLE**
  - `in_ready` = 1.
  - ALU word = 101010 (constant 0).
  - On `in_valid && in_ready`: `acc` <= 0, `mcand` <= b, `mplier` <= a, `cnt` <= 0, go to ADD.
- **ADD**
  - ALU x = `acc`, y = `mcand`, word = 000010 (x+y).
  - If `mplier[0]`, `acc` <= alu.o; otherwise `acc` holds.
  - Go to DBL.
- **DBL**
  - ALU x = y = `mcand`, word = 000010.
  - `mcand` <= alu.o (left shift by 1).
  - `mplier` <= `mplier` >> 1 (logical).
  - `cnt` <= `cnt` + 1.
  - If `cnt` == 15, go to FLAGS; otherwise go to ADD.
- **FLAGS**
  - ALU x = `acc`, word = 001100 (pass x).
  - `product` <= alu.o, `zr` <= alu.zr, `ng` <= alu.ng.
  - Go to DONE.
- **DONE**
  - `out_valid` = 1; `product`, `zr` and `ng` are stable.
  - ALU word = 101010.
  - On `out_ready`, go to IDLE.
- Arithmetic wraps mod 2^16 and carries out of bit 15 are discarded. No overflow flag exists.
- There is no early exit. All 16 iterations always run, so latency is independent of the data.
- `in_valid` outside IDLE is ignored and the operands are not captured. The upstream holds `a`/`b` until `in_ready`.
- Reset mid-operation aborts the operation with no result produced. The block returns to IDLE with reset values.

## Timing
- **Values after the reset edge:**
  - State is IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `product`=0, `zr`=0, `ng`=0.
  - `alu_ctrl`=6'b101010.
  - `acc`, `mcand`, `mplier` and `cnt` are all 0.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from registered state, with no combinational path from the inputs.
- **Schedule:**
  - Accept edge E0.
  - ADD/DBL pairs occupy cycles E0..E32 (32 cycles).
  - FLAGS runs in cycle E32..E33.
  - `out_valid` rises after E33, which is 33 cycles of latency.
- `out_ready` high while `out_valid` completes the transfer at the next edge. `in_ready` rises one cycle later (IDLE).
- The minimum issue interval is 35 cycles. `out_ready` held high is legal and gives this minimum.
- `product`, `zr` and `ng` hold their last values after the transfer until the next FLAGS.
- `alu_ctrl` changes only on edges and matches the state encoding above every cycle.

## Test plan
- a=3, b=5, out_ready=1 → `out_valid` exactly 33 cycles after accept; `product`=15, `zr`=0, `ng`=0. `alu_ctrl` sequence is 000010 ×32, then 001100.
- a=0, b=random → `product`=0, `zr`=1, `ng`=0. a=16'hFFFF, b=1 → `product`=16'hFFFF, `ng`=1.
- Wrap and sign cases:
  - a=16'h0100, b=16'h0100 → `product`=0, `zr`=1.
  - a=16'hFFFD (−3), b=7 → `product`=16'hFFEB (−21), `ng`=1.
  - 200 random pairs → match against a*b mod 2^16.
- Backpressure: hold out_ready=0 for 10 cycles after `out_valid` → `out_valid` and `product` stay stable and `in_ready`=0. Then raise out_ready → `in_ready`=1 one edge later.
- Busy-time inputs: pulse in_valid with new a/b during ADD/DBL → ignored, and the result equals the first pair's product.
- Reset during iteration 8: assert rst_n=0 for 1 cycle → all reset values above. A following a=2, b=9 yields 18 with normal 33-cycle latency.
